// File: rtl/sram_seq.sv
// sram_seq: arbitrated single-port async SRAM sequencer shared by a CPU port
// and a read-only video fetch port. Fixed-length strobe sequences; all
// outputs come straight from flops.
module sram_seq #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [2:0]  cpu_page,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  output logic [18:0] sram_addr,
  input  logic [7:0]  sram_dq_i,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WR, WHOLD, ACK} state_t;

  localparam logic [2:0] WLOAD = 3'(WAIT_CYCLES);

  state_t     state;
  logic [2:0] wcnt;
  logic       own_vid;
  logic       last_vid;
  logic       grant_vid;

  // Video wins a tie unless it won the previous grant, so both ports alternate.
  assign grant_vid = vid_req && (!cpu_req || !last_vid);

  // Sequencer: grant, strobe timing, data capture and ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      own_vid    <= 1'b0;
      last_vid   <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (vid_req || cpu_req) begin
            own_vid   <= grant_vid;
            last_vid  <= grant_vid;
            sram_ce_n <= 1'b0;
            if (grant_vid) begin
              sram_addr <= {3'b000, vid_addr};
              sram_oe_n <= 1'b0;
              wcnt      <= WLOAD;
              state     <= RD;
            end else begin
              sram_addr <= {cpu_page, cpu_addr};
              sram_dq_o <= cpu_wdata;
              if (cpu_we) begin
                sram_dq_oe <= 1'b1;
                state      <= WSETUP;
              end else begin
                sram_oe_n <= 1'b0;
                wcnt      <= WLOAD;
                state     <= RD;
              end
            end
          end
        end
        RD: begin
          if (wcnt == 3'd0) begin
            if (own_vid) begin
              vid_rdata <= sram_dq_i;
              vid_ack   <= 1'b1;
            end else begin
              cpu_rdata <= sram_dq_i;
              cpu_ack   <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= ACK;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        WSETUP: begin
          sram_we_n <= 1'b0;
          wcnt      <= WLOAD;
          state     <= WR;
        end
        WR: begin
          if (wcnt == 3'd0) begin
            sram_we_n <= 1'b1;
            state     <= WHOLD;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        WHOLD: begin
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          cpu_ack    <= 1'b1;
          state      <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_seq.sv
// Bench for sram_seq: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sram_seq;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [15:0] cpu_addr = '0, vid_addr = '0;
  logic [2:0]  cpu_page = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack, vid_ack, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  cpu_rdata, vid_rdata, sram_dq_i, sram_dq_o;
  logic [18:0] sram_addr;

  // second instance, WAIT_CYCLES = 0
  logic        z_req = 1'b0;
  logic        z_ack, z_vack, z_oe, z_ce_n, z_oe_n, z_we_n;
  logic [7:0]  z_rdata, z_vrdata, z_dq_o, z_dq_i;
  logic [18:0] z_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic started = 1'b0;

  logic [7:0] mem [0:(1<<19)-1];

  always #5 clk = ~clk;

  sram_seq #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_page(cpu_page), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n));

  sram_seq #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .cpu_req(z_req), .cpu_we(1'b0),
    .cpu_addr(16'h0011), .cpu_page(3'd0), .cpu_wdata(8'h00),
    .cpu_ack(z_ack), .cpu_rdata(z_rdata), .vid_req(1'b0),
    .vid_addr(16'h0000), .vid_ack(z_vack), .vid_rdata(z_vrdata),
    .sram_addr(z_addr), .sram_dq_i(z_dq_i), .sram_dq_o(z_dq_o),
    .sram_dq_oe(z_oe), .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n),
    .sram_we_n(z_we_n));

  // SRAM models: main instance uses a real array, the second a fixed pattern
  assign sram_dq_i = mem[sram_addr];
  assign z_dq_i    = z_addr[7:0] ^ 8'h3C;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_k counts cycles since the grant edge; the access lasts m_lat cycles,
  // the last of which carries the ack.
  logic        m_busy = 1'b0, m_vid = 1'b0, m_we = 1'b0, m_last_vid = 1'b0;
  int          m_k = 0;
  logic [18:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, m_rd = '0, m_crd = '0, m_vrd = '0;
  logic        m_gv;
  int          m_lat;

  assign m_gv  = vid_req && !(cpu_req && m_last_vid);
  assign m_lat = m_we ? W + 4 : W + 2;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_k <= 0; m_last_vid <= 1'b0; m_vid <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_crd <= '0; m_vrd <= '0;
    end else if (!m_busy) begin
      if (vid_req || cpu_req) begin
        m_busy     <= 1'b1;
        m_k        <= 1;
        m_vid      <= m_gv;
        m_last_vid <= m_gv;
        m_we       <= !m_gv && cpu_we;
        m_addr     <= m_gv ? {3'b000, vid_addr} : {cpu_page, cpu_addr};
        m_rd       <= m_gv ? mem[{3'b000, vid_addr}] : mem[{cpu_page, cpu_addr}];
        m_wdata    <= cpu_wdata;
      end
    end else if (m_k == m_lat) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat && !m_we) begin
        if (m_vid) m_vrd <= m_rd;
        else       m_crd <= m_rd;
      end
    end
  end

  // every-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    if (started) begin
      chk("cpu_ack",   32'(cpu_ack),    32'(m_busy && m_k == m_lat && !m_vid));
      chk("vid_ack",   32'(vid_ack),    32'(m_busy && m_k == m_lat && m_vid));
      chk("cpu_rdata", 32'(cpu_rdata),  32'(m_crd));
      chk("vid_rdata", 32'(vid_rdata),  32'(m_vrd));
      chk("ce_n",      32'(sram_ce_n),  32'(!(m_busy && m_k >= 1 && m_k < m_lat)));
      chk("oe_n",      32'(sram_oe_n),  32'(!(m_busy && !m_we && m_k >= 1 && m_k < m_lat)));
      chk("we_n",      32'(sram_we_n),  32'(!(m_busy && m_we && m_k >= 2 && m_k <= W + 2)));
      chk("dq_oe",     32'(sram_dq_oe), 32'(m_busy && m_we && m_k >= 1 && m_k < m_lat));
      chk("sram_addr", 32'(sram_addr),  32'(m_addr));
      chk("oe_vs_dq",  32'(!sram_oe_n && sram_dq_oe), 32'(0));
      if (sram_dq_oe) chk("dq_o", 32'(sram_dq_o), 32'(m_wdata));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input logic vid, input logic we, input logic [2:0] page,
                        input logic [15:0] addr, input logic [7:0] data,
                        output int lat, output int oe_cnt, output int we_cnt,
                        output int dq_cnt, output int other_ack,
                        output logic [18:0] a);
    logic done;
    @(negedge clk);
    if (vid) begin vid_req = 1'b1; vid_addr = addr; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; end
    cpu_page = page;
    lat = 0; oe_cnt = 0; we_cnt = 0; dq_cnt = 0; other_ack = 0; done = 1'b0; a = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) dq_cnt++;
      if (vid ? cpu_ack : vid_ack) other_ack++;
      if (vid ? vid_ack : cpu_ack) begin done = 1'b1; a = sram_addr; break; end
    end
    chk("ack_seen", 32'(done), 32'(1));
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  initial begin
    int lat, oec, wec, dqc, oth;
    logic [18:0] a;
    logic [3:0] order;
    int nack;
    logic [8:0] ack_pat, oe_pat;

    for (int i = 0; i < (1 << 19); i++)
      mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'(i >> 16);
    mem[19'h2A123] = 8'h5A;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    started = 1'b1;
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    chk("rst_addr",      32'(sram_addr), 32'h0);
    chk("rst_ce_n",      32'(sram_ce_n), 32'h1);
    chk("rst_dq_oe",     32'(sram_dq_oe), 32'h0);

    // CPU read, page 2
    access(1'b0, 1'b0, 3'd2, 16'hA123, 8'h00, lat, oec, wec, dqc, oth, a);
    chk("rd_addr",  32'(a), 32'h2A123);
    chk("rd_oe",    32'(oec), 32'd2);
    chk("rd_lat",   32'(lat), 32'd3);
    chk("rd_data",  32'(cpu_rdata), 32'h5A);

    // video read with cpu_page nonzero
    access(1'b1, 1'b0, 3'd3, 16'h8000, 8'h00, lat, oec, wec, dqc, oth, a);
    chk("vid_addr",    32'(a), 32'h08000);
    chk("vid_cpu_ack", 32'(oth), 32'd0);
    chk("vid_cpu_rd",  32'(cpu_rdata), 32'h5A);
    chk("vid_data",    32'(vid_rdata), 32'h80);

    // CPU write
    access(1'b0, 1'b1, 3'd0, 16'h1000, 8'hC3, lat, oec, wec, dqc, oth, a);
    chk("wr_dq_oe", 32'(dqc), 32'd4);
    chk("wr_we",    32'(wec), 32'd2);
    chk("wr_oe",    32'(oec), 32'd0);
    chk("wr_lat",   32'(lat), 32'd5);
    @(negedge clk);
    chk("wr_mem",   32'(mem[19'h01000]), 32'hC3);

    // both requesters held: must alternate starting with video
    cpu_we = 1'b0; cpu_page = 3'd0; cpu_addr = 16'h0005; vid_addr = 16'h0006;
    cpu_req = 1'b1; vid_req = 1'b1;
    nack = 0; order = '0;
    for (int i = 0; i < 40 && nack < 4; i++) begin
      @(negedge clk);
      if (vid_ack || cpu_ack) begin
        order = {order[2:0], vid_ack};
        nack++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    chk("arb_count", 32'(nack), 32'd4);
    chk("arb_order", 32'(order), 32'b1010);

    // reset in the second WR cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2222; cpu_wdata = 8'h11;
    repeat (3) @(negedge clk);
    chk("abort_in_wr", 32'(sram_we_n), 32'd0);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_we_n",  32'(sram_we_n), 32'd1);
    chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_ack",   32'(cpu_ack), 32'd0);
    chk("abort_ce_n",  32'(sram_ce_n), 32'd1);
    reset = 1'b0;
    access(1'b0, 1'b1, 3'd1, 16'h0042, 8'h77, lat, oec, wec, dqc, oth, a);
    chk("post_wr_lat", 32'(lat), 32'd5);
    access(1'b0, 1'b0, 3'd1, 16'h0042, 8'h00, lat, oec, wec, dqc, oth, a);
    chk("post_rd", 32'(cpu_rdata), 32'h77);

    // WAIT_CYCLES=0, back-to-back reads with request held
    @(negedge clk);
    z_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ack_pat[i] = z_ack;
      oe_pat[i]  = !z_oe_n;
    end
    z_req = 1'b0;
    chk("w0_ack_pat", 32'(ack_pat), 32'b010010010);
    chk("w0_oe_pat",  32'(oe_pat),  32'b001001001);
    chk("w0_rdata",   32'(z_rdata), 32'h2D);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_seq.md
SRAM_SEQ -- requirements
Module: sram_seq

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra clk cycles the strobe stays low beyond the first strobe cycle; legal range 0..7.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 cpu_req  in  1  CPU access request; level, held until cpu_ack.
REQ-005 cpu_we  in  1  1 = write, 0 = read; valid while cpu_req high.
REQ-006 cpu_addr  in  16  CPU logical address.
REQ-007 cpu_page  in  3  RAM-disk page from the mapper's bigram_addr; 0 = main RAM.
REQ-008 cpu_wdata  in  8  write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse for a CPU access.
REQ-010 cpu_rdata  out  8  CPU read data; held until the next CPU read completes.
REQ-011 vid_req  in  1  video fetch request (read only); level, held until vid_ack.
REQ-012 vid_addr  in  16  video fetch address; always page 0.
REQ-013 vid_ack  out  1  one-cycle completion pulse for a video fetch.
REQ-014 vid_rdata  out  8  video read data; held until the next video read completes.
REQ-015 sram_addr  out  19  physical address = {page[2:0], addr[15:0]}.
REQ-016 sram_dq_i  in  8  SRAM data bus input.
REQ-017 sram_dq_o  out  8  SRAM data bus output.
REQ-018 sram_dq_oe  out  1  1 = drive sram_dq_o onto the bus.
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-020 FSM states: IDLE, RD, WSETUP, WR, WHOLD, ACK; all outputs registered.
REQ-021 Requests are sampled only in IDLE; in all other states the req inputs are ignored.
REQ-022 Arbitration in IDLE: vid_req alone -> grant video; cpu_req alone -> grant CPU.
REQ-023 Both requests pending: grant video, unless the previous grant was video, in which case grant CPU.
REQ-024 The last-grant flag updates on every grant; its reset value is CPU.
REQ-025 On grant: latch sram_addr, grant owner, direction and write data; sram_addr stays stable until the next grant.
REQ-026 Read path: IDLE -> RD; sram_ce_n = 0 and sram_oe_n = 0 for exactly WAIT_CYCLES+1 cycles.
REQ-027 Read data: sample sram_dq_i on the final RD cycle into the owner's rdata register, then go to ACK.
REQ-028 Write path: IDLE -> WSETUP (1 cycle: ce_n = 0, we_n = 1, dq_oe = 1) -> WR (WAIT_CYCLES+1 cycles: we_n = 0) -> WHOLD (1 cycle: we_n = 1, dq_oe = 1) -> ACK.
REQ-029 sram_dq_oe is 1 only in WSETUP, WR and WHOLD; sram_oe_n is never 0 while sram_dq_oe = 1.
REQ-030 ACK state (1 cycle): pulse the owner's ack, strobes inactive, then go to IDLE.
REQ-031 The requester deasserts req on seeing ack; a req still high in the following IDLE cycle starts a new access.
REQ-032 The non-owner's ack and rdata never change during another owner's access.
REQ-033 A video access always drives page 0 regardless of cpu_page.
REQ-034 Wait counter is 3 bits; it loads WAIT_CYCLES on entry to RD or WR and decrements to 0; exit occurs on the cycle the count reaches 0.
REQ-035 Read latency: grant cycle to ack = WAIT_CYCLES+2 cycles; write latency = WAIT_CYCLES+4 cycles.

Reset
REQ-036 When reset is high at a rising edge: state = IDLE; sram_ce_n, sram_oe_n and sram_we_n = 1; sram_dq_oe = 0; both acks = 0; both rdata = 0; sram_addr = 0; last-grant = CPU.
REQ-037 Reset aborts any access mid-cycle with no ack issued; the strobes go inactive in the same edge.

Verification
REQ-038 WAIT_CYCLES=1, CPU read, cpu_page=2, cpu_addr=0xA123, SRAM returns 0x5A -> sram_addr=0x2A123, oe_n low for 2 cycles, cpu_ack 3 cycles after grant, cpu_rdata=0x5A.
REQ-039 CPU write, page 0, addr 0x1000, data 0xC3 -> dq_oe for 4 cycles, we_n low for 2 cycles inside them, cpu_ack 5 cycles after grant, SRAM model holds 0xC3 at 0x01000.
REQ-040 vid_req and cpu_req asserted in the same cycle and held -> grant order video, CPU, video, CPU; no requester is starved.
REQ-041 Video read at vid_addr=0x8000 while cpu_page=3 -> sram_addr=0x08000, vid_ack pulses, cpu_ack stays 0, cpu_rdata unchanged.
REQ-042 Reset asserted in the second WR cycle -> next edge: we_n=1, dq_oe=0, IDLE, no cpu_ack; a new request after reset completes normally.
REQ-043 WAIT_CYCLES=0, back-to-back CPU reads with req held -> each access is RD(1)+ACK(1)+IDLE(1), one ack per access.
